ram_dp_pipe: RTL
================

RAM_DP_PIPE -- requirements
Module: ram_dp_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 19, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 307200, number of words (DEPTH <= 2^ADDR_W).
REQ-004 SHALL have parameter RD_LAT, default 2, read latency in cycles (legal 1..4).
REQ-005 SHALL have port clock, input, 1, single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports address_a and address_b, input, ADDR_W, port A and port B word addresses.
REQ-008 SHALL have ports data_a and data_b, input, DATA_W, write data.
REQ-009 SHALL have ports wren_a and wren_b, input, 1, write enables.
REQ-010 SHALL have ports rden_a and rden_b, input, 1, read requests.
REQ-011 SHALL have ports q_a and q_b, output, DATA_W, read data.
REQ-012 SHALL have ports q_valid_a and q_valid_b, output, 1, read data qualifier, one-cycle pulse per read.
REQ-013 SHALL have port clear, input, 1, pulse that starts a full-memory zero fill.
REQ-014 SHALL have port busy, output, 1, high while the zero fill runs.

Function
REQ-015 SHALL make q_x/q_valid_x respond exactly RD_LAT cycles after the edge sampling rden_x=1; rden_x=0 yields q_valid_x=0 and holds q_x.
REQ-016 SHALL accept one read and/or one write per port per cycle, fully pipelined, with no back-pressure.
REQ-017 SHALL return the old word on a read of an address being written in the same cycle by either port (read-first).
REQ-018 SHALL store data_a when both ports write the same address in the same cycle (port A wins).
REQ-019 SHALL ignore writes with address >= DEPTH; reads with address >= DEPTH SHALL return 0 with q_valid asserted.
REQ-020 SHALL implement FSM IDLE/CLEAR: IDLE with clear=1 -> CLEAR with counter=0; CLEAR writes 0 at counter each cycle; after writing DEPTH-1 -> IDLE.
REQ-021 SHALL hold busy=1 exactly DEPTH cycles, from the cycle after clear is sampled through the cycle writing DEPTH-1.
REQ-022 SHALL drop user writes on both ports while busy=1; reads SHALL still be serviced and return current contents.
REQ-023 SHALL ignore clear while busy=1.

Reset
REQ-024 SHALL, with reset_n=0, force q_a=q_b=0, q_valid_a=q_valid_b=0, busy=0, FSM=IDLE, counter=0, and flush all in-flight reads.
REQ-025 SHALL NOT alter memory contents on reset; a reset mid-clear leaves memory partially zeroed.
REQ-026 SHALL accept requests on the first rising edge after reset_n deasserts.

Configuration
REQ-027 SHALL honour macro RAM_DP_WRITE_FIRST_EN: when defined, a same-cycle read of an address being written returns the newly written word, including the port A winner under REQ-018.
REQ-028 SHALL, without RAM_DP_WRITE_FIRST_EN, follow read-first behaviour per REQ-017.

Verification (DEPTH=16, ADDR_W=4, DATA_W=8, RD_LAT=2 unless stated)
REQ-029 SHALL cover latency: write A[3]=0x5A; read B[3] at cycle t -> q_b=0x5A, q_valid_b=1 at t+2 only; repeat with RD_LAT=1 and 4 -> t+1 and t+4.
REQ-030 SHALL cover collision: A[7] holds 0x11; A writes 0x22 and B writes 0x33 to addr 7 while B reads 7 -> q_b=0x11, later read returns 0x22; with RAM_DP_WRITE_FIRST_EN, q_b=0x22.
REQ-031 SHALL cover clear: fill all with 0xFF; pulse clear -> busy high 16 cycles; write to addr 0 during busy dropped; all 16 reads then return 0x00.
REQ-032 SHALL cover reset mid-clear: assert reset_n=0 at clear cycle 5 -> busy=0, q_valid=0 immediately; addr 0..4 read 0x00, addr 5..15 read 0xFF.
REQ-033 SHALL cover range: DEPTH=12; write 0xAB to addr 13 -> no effect; read addr 13 -> q=0x00 with q_valid=1.
REQ-034 SHALL cover back-to-back traffic: reads on both ports every cycle for 32 cycles against random writes -> q/q_valid match a read-first reference model cycle-exact.

Source files
------------

// File: rtl/ram_dp_pipe.sv
// Dual-port RAM with registered reads (latency RD_LAT) and a full-memory zero fill.
// Define RAM_DP_WRITE_FIRST_EN to make same-cycle reads return the word being written.
module ram_dp_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 307200,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_a,
  input  logic              wren_b,
  input  logic              rden_a,
  input  logic              rden_b,
  input  logic              clear,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              q_valid_a,
  output logic              q_valid_b,
  output logic              busy
);

  // state   | meaning
  // S_IDLE  | normal operation, user writes accepted, waiting for clear
  // S_CLEAR | zero fill walking clr_cnt from 0 to DEPTH-1, user writes dropped
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_we;

  logic                in_rng_a;
  logic                in_rng_b;
  logic                we_a;
  logic                we_b;
  logic [DATA_W-1:0]   rdata_a;
  logic [DATA_W-1:0]   rdata_b;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [RD_LAT-1:0]   vld_a;
  logic [RD_LAT-1:0]   vld_b;
  logic [DATA_W-1:0]   pipe_a [RD_LAT];
  logic [DATA_W-1:0]   pipe_b [RD_LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) clr_cnt <= '0;
      else                 clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clear) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    if (state == S_CLEAR) begin
      busy   = 1'b1;
      clr_we = 1'b1;
    end
  end

  assign in_rng_a = {1'b0, address_a} < DEPTH_L;
  assign in_rng_b = {1'b0, address_b} < DEPTH_L;
  assign we_a     = wren_a && in_rng_a && !busy;
  assign we_b     = wren_b && in_rng_b && !busy;

  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (we_b) mem[address_b] <= data_b;
      if (we_a) mem[address_a] <= data_a;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (in_rng_a) begin
      rdata_a = mem[address_a];
`ifdef RAM_DP_WRITE_FIRST_EN
      if (clr_we && (clr_cnt == address_a))           rdata_a = '0;
      else if (we_a)                                  rdata_a = data_a;
      else if (we_b && (address_b == address_a))      rdata_a = data_b;
`endif
    end
  end

  always_comb begin
    rdata_b = '0;
    if (in_rng_b) begin
      rdata_b = mem[address_b];
`ifdef RAM_DP_WRITE_FIRST_EN
      if (clr_we && (clr_cnt == address_b))           rdata_b = '0;
      else if (we_a && (address_a == address_b))      rdata_b = data_a;
      else if (we_b)                                  rdata_b = data_b;
`endif
    end
  end

  // Data stages only load on a valid read so q holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_a <= '0;
      vld_b <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      vld_a[0] <= rden_a;
      vld_b[0] <= rden_b;
      if (rden_a) pipe_a[0] <= rdata_a;
      if (rden_b) pipe_b[0] <= rdata_b;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_a[i] <= vld_a[i-1];
        vld_b[i] <= vld_b[i-1];
        if (vld_a[i-1]) pipe_a[i] <= pipe_a[i-1];
        if (vld_b[i-1]) pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign q_a       = pipe_a[RD_LAT-1];
  assign q_b       = pipe_b[RD_LAT-1];
  assign q_valid_a = vld_a[RD_LAT-1];
  assign q_valid_b = vld_b[RD_LAT-1];

endmodule
